uart_tx: RTL and testbench

//  - 8N1 UART transmitter; the sending end of the link that uart_rx receives.
//  - Serialises parallel bytes from the console-mux core onto one serial line: start bit, 8 data bits LSB first, stop bit.
//  - Has a one-byte holding register, so the core can queue the next byte while a frame is on the line.
//  - Frames run back-to-back with no idle gap.

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_baud_cnt.sv | 27 ++
 rtl/uart_tx.sv | 139 +++++++++++++
 tb/tb_uart_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared UART definitions (also intended for uart_rx).
//   UART_DATA_BITS       - data bits per frame
//   UART_CLK_PER_BIT_DEF - default clk cycles per bit period
//   uart_state_e         - FSM state encodings (IDLE, START, DATA, PARITY, STOP)
package uart_tx_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int UART_CLK_PER_BIT_DEF = 100;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, counts 0..CLK_PER_BIT-1 and wraps.
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   clear in  hold the count at 0 (line idle)
//   tick  out high on the last cycle of a bit period (count == CLK_PER_BIT-1)
module uart_baud_cnt #(
  parameter int CLK_PER_BIT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

  logic [CW-1:0] clk_cnt;

  assign tick = (clk_cnt == CW'(CLK_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear)  clk_cnt <= '0;
    else if (tick)     clk_cnt <= '0;
    else               clk_cnt <= clk_cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a one-byte holding register.
// Frames go back-to-back with no idle gap while the holding register is full.
//   clk         in  clock, rising edge
//   rst         in  synchronous active-high reset (aborts any frame, drops queued byte)
//   in_valid    in  byte on in_data offered
//   in_data     in  byte to send
//   in_ready    out holding register empty (registered)
//   serial_line out TX line, idle high, driven from a flop
//   busy        out frame on the line
//   done        out one-cycle pulse on the last cycle of each stop bit
// Config macro: UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       serial_line,
  output logic       busy,
  output logic       done
);

  uart_state_e state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] hold_q;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       hold_full_q, hold_full_d;
  logic       tick, load, accept, line_d;
`ifdef UART_TX_PARITY_EN
  logic       par_q;
`endif

  uart_baud_cnt #(.CLK_PER_BIT(CLK_PER_BIT)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == UART_IDLE),
    .tick  (tick)
  );

  assign accept = in_valid && in_ready;
  assign busy   = (state_q != UART_IDLE);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    load      = 1'b0;
    done      = 1'b0;
    case (state_q)
      UART_IDLE:
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = UART_START;
        end
      UART_START:
        if (tick) begin
          state_d   = UART_DATA;
          bit_idx_d = 3'd0;
        end
      UART_DATA:
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = UART_PARITY;
`else
            state_d = UART_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
      UART_PARITY:
        if (tick) state_d = UART_STOP;
`endif
      UART_STOP:
        if (tick) begin
          done = 1'b1;
          // A queued byte starts its frame on the very next cycle.
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = UART_START;
          end else begin
            state_d = UART_IDLE;
          end
        end
      default: state_d = UART_IDLE;
    endcase
    if (load) shift_d = hold_q;

    hold_full_d = accept | (hold_full_q & ~load);

    // Line value is computed for the next state so the flop output lines up
    // with the state change (line low on the load edge).
    case (state_d)
      UART_START:  line_d = 1'b0;
      UART_DATA:   line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      UART_PARITY: line_d = par_q;
`endif
      default:     line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UART_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      hold_full_q <= 1'b0;
      in_ready    <= 1'b1;
      serial_line <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      hold_full_q <= hold_full_d;
      in_ready    <= ~hold_full_d;
      serial_line <= line_d;
    end
  end

  // Data registers need no reset; hold_full_q qualifies their contents.
  always_ff @(posedge clk) begin
    if (accept) hold_q <= in_data;
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)       par_q <= 1'b0;
    else if (load) par_q <= ^hold_q;
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. The driver pushes each accepted
// byte into exp_q; a line monitor decodes frames mid-bit and pops/compares.
module tb_uart_tx;

  localparam int CPB = 100;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS     = 11;
  localparam int EXP_LOW00 = 10 * CPB;  // start + 8 zeros + parity 0
  localparam int EXP_RUNFF = 2;         // start and parity 0
`else
  localparam int NBITS     = 10;
  localparam int EXP_LOW00 = 9 * CPB;
  localparam int EXP_RUNFF = 1;
`endif
  localparam int FRAME  = NBITS * CPB;
  localparam int BUDGET = 4 * FRAME;

  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, serial_line, busy, done;

  uart_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .serial_line(serial_line), .busy(busy), .done(done)
  );

  always #1 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- line monitor ----------------
  bit         rx_active = 0;
  int         rx_cnt, rx_frames = 0;
  logic [7:0] rx_sh, last_rx;
  logic       last_par;
  int         fall_cyc = 0, prev_fall_cyc = 0, done_cyc = 0, done_cnt = 0, idle_cyc = 0;
  int         low_run = 0, last_low_run = 0, low_runs = 0;
  logic       line_prev = 1'b1, busy_prev = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (busy_prev === 1'b1 && busy === 1'b0) idle_cyc = cyc;
    busy_prev = busy;
    if (serial_line === 1'b0) low_run++;
    else if (line_prev === 1'b0) begin last_low_run = low_run; low_runs++; low_run = 0; end
    line_prev = serial_line;

    if (rst) rx_active = 0;
    else if (!rx_active) begin
      if (serial_line === 1'b0) begin
        rx_active = 1; rx_cnt = 0;
        prev_fall_cyc = fall_cyc; fall_cyc = cyc;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        int k;
        k = rx_cnt / CPB;
        if (k == 0) chk("start_bit", serial_line, 1'b0);
        else if (k <= 8) rx_sh = {serial_line, rx_sh[7:1]};
`ifdef UART_TX_PARITY_EN
        else if (k == 9) begin
          last_par = serial_line;
          chk("parity_bit", serial_line, ^rx_sh);
        end
`endif
        if (k == NBITS - 1) begin
          chk("stop_bit", serial_line, 1'b1);
          last_rx = rx_sh;
          rx_frames++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx_unexpected: got 0x%0h, expected no frame", rx_sh);
          end else chk("rx_byte", rx_sh, exp_q.pop_front());
          rx_active = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [7:0] b, input bit keep_valid, output int acc_cyc);
    int n = 0;
    if (!in_valid) @(negedge clk);
    in_valid = 1'b1; in_data = b;
    while (in_ready !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) begin
      checks++; errors++;
      $display("FAIL send_timeout: byte 0x%0h never accepted", b);
      in_valid = 1'b0; acc_cyc = -1;
      return;
    end
    @(posedge clk);
    exp_q.push_back(b);
    @(negedge clk);
    acc_cyc = cyc;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || in_ready !== 1'b1 || rx_active) && n < BUDGET) begin
      @(negedge clk); n++;
    end
    if (n >= BUDGET) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0b in_ready=%0b", busy, in_ready);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, f0, fr0, dn0, lr0, n;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_line", serial_line, 1'b1);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single byte
    send(8'hE1, 0, a1);
    wait_idle();
    chk("t1_latency", fall_cyc - a1, 1);
    chk("t1_done_cycle", done_cyc - fall_cyc + 1, FRAME);
    chk("t1_frame_len", idle_cyc - fall_cyc, FRAME);
    chk("t1_rx", last_rx, 8'hE1);

    // 2: back-to-back, second byte offered while busy
    send(8'h55, 0, a1);
    send(8'hAA, 0, a2);
    chk("t2_ready_gap", a2 - a1, 2);
    repeat (CPB) @(negedge clk);
    chk("t2_ready_low_busy", in_ready, 1'b0);
    wait_idle();
    chk("t2_no_gap", fall_cyc - prev_fall_cyc, FRAME);
    chk("t2_last_rx", last_rx, 8'hAA);

    // 3: backpressure with in_valid held
    fr0 = rx_frames;
    send(8'h01, 1, a1);
    send(8'h02, 1, a2);
    send(8'h03, 0, a3);
    f0 = a1 + 1;
    wait_idle();
    chk("t3_frames", rx_frames - fr0, 3);
    chk("t3_total_cycles", idle_cyc - f0, 3 * FRAME);
    chk("t3_last_rx", last_rx, 8'h03);

    // 4: reset in DATA bit 4 with a byte queued
    dn0 = done_cnt; fr0 = rx_frames;
    send(8'h0F, 0, a1);
    send(8'h99, 0, a2);
    n = 0;
    while (cyc < a1 + 1 + 5 * CPB + CPB / 2 && n < BUDGET) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_line", serial_line, 1'b1);
    chk("t4_rst_in_ready", in_ready, 1'b1);
    chk("t4_rst_busy", busy, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_no_done", done_cnt - dn0, 0);
    send(8'h3C, 0, a3);
    wait_idle();
    chk("t4_rx", last_rx, 8'h3C);
    chk("t4_frames", rx_frames - fr0, 1);
    chk("t4_done_once", done_cnt - dn0, 1);

    // 5: boundaries
    send(8'h00, 0, a1);
    wait_idle();
    chk("t5_low00", last_low_run, EXP_LOW00);
    chk("t5_rx00", last_rx, 8'h00);
    lr0 = low_runs;
    send(8'hFF, 0, a1);
    wait_idle();
    chk("t5_runsFF", low_runs - lr0, EXP_RUNFF);
    chk("t5_lowFF", last_low_run, CPB);
    chk("t5_rxFF", last_rx, 8'hFF);

`ifdef UART_TX_PARITY_EN
    // 6: parity frame
    send(8'h07, 0, a1);
    wait_idle();
    chk("t6_parity", last_par, 1'b1);
    chk("t6_done_cycle", done_cyc - fall_cyc + 1, 11 * CPB);
    chk("t6_frame_len", idle_cyc - fall_cyc, 11 * CPB);
    chk("t6_rx", last_rx, 8'h07);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
